// File: rtl/z80_dma_arbiter.sv
// z80_dma_arbiter: lets one DMA requester borrow the Z80 bus through the
// BUSRQ/BUSAK handshake. It runs T1/T2/T3 memory cycles with programmable wait
// states, bursts up to MAX_BURST accesses, and then enforces a hold-off so
// the CPU keeps making progress.
module z80_dma_arbiter #(
   parameter int WAIT_CYC    = 1,
   parameter int MAX_BURST   = 4,
   parameter int HOLDOFF     = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_req,
   input  logic        dma_rnw,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic        dma_done,
   output logic        dma_err,
   output logic [7:0]  dma_rdata,
   output logic        busrq_n,
   input  logic        busak_n,
   output logic        bus_oe,
   output logic [15:0] a_out,
   output logic [7:0]  d_out,
   output logic        d_oe,
   input  logic [7:0]  d_in,
   output logic        mreq_n,
   output logic        rd_n,
   output logic        wr_n
);

   localparam int HW = $clog2(HOLDOFF + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int WW = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_ACQ, S_ABORT, S_T1, S_T2, S_T3, S_REL
   } state_t;

   state_t         state_reg, state_next;
   logic           busak_s1_reg, busak_s_reg;
   logic [HW-1:0]  hold_reg;
   logic [TW-1:0]  to_reg;
   logic [BW-1:0]  burst_reg;
   logic [WW-1:0]  wait_reg;
   logic           rnw_reg;
   logic [15:0]    addr_reg;
   logic [7:0]     wdata_reg;
   logic [7:0]     rdata_reg;
   logic           done_reg;
   logic           dhold_reg;

   // State register, BUSAK synchroniser, counters and the access latches
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         busak_s1_reg <= 1'b1;
         busak_s_reg  <= 1'b1;
         hold_reg     <= '0;
         to_reg       <= '0;
         burst_reg    <= '0;
         wait_reg     <= '0;
         rnw_reg      <= 1'b1;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rdata_reg    <= '0;
         done_reg     <= 1'b0;
         dhold_reg    <= 1'b0;
      end else begin
         busak_s1_reg <= busak_n;
         busak_s_reg  <= busak_s1_reg;
         state_reg    <= state_next;
         // dma_done for an access lands on the cycle after its T3
         done_reg     <= (state_reg == S_T3);
         // Write data stays driven for one cycle after wr_n rises
         dhold_reg    <= (state_reg == S_T3) && !rnw_reg;
         if ((state_reg == S_REL && state_next == S_IDLE) || state_reg == S_ABORT)
            hold_reg <= HW'(HOLDOFF);
         else if (hold_reg != '0)
            hold_reg <= hold_reg - 1'b1;
         to_reg   <= (state_reg == S_ACQ) ? to_reg + 1'b1 : '0;
         wait_reg <= (state_reg == S_T2) ? wait_reg + 1'b1 : '0;
         if (state_reg == S_ACQ)
            burst_reg <= '0;
         else if (state_reg == S_T3 && state_next == S_T1)
            burst_reg <= burst_reg + 1'b1;
         // The requester holds its request stable until dma_ack, so latch on T1 entry
         if (state_next == S_T1) begin
            rnw_reg   <= dma_rnw;
            addr_reg  <= dma_addr;
            wdata_reg <= dma_wdata;
         end
         if (state_reg == S_T3 && rnw_reg)
            rdata_reg <= d_in;
      end
   end

   // Next-state decode and bus/requester outputs
   always_comb begin
      state_next = state_reg;
      busrq_n    = 1'b1;
      bus_oe     = 1'b0;
      mreq_n     = 1'b1;
      rd_n       = 1'b1;
      wr_n       = 1'b1;
      dma_ack    = 1'b0;
      dma_err    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            // busak_s must be high too, so a late BUSAK after an abort is waited out
            if (dma_req && hold_reg == '0 && busak_s_reg)
               state_next = S_ACQ;
         end
         S_ACQ: begin
            busrq_n = 1'b0;
            if (!busak_s_reg)
               state_next = dma_req ? S_T1 : S_REL;
            else if (to_reg == TW'(ACK_TIMEOUT - 1))
               state_next = S_ABORT;
         end
         S_ABORT: begin
            dma_ack    = 1'b1;
            dma_err    = 1'b1;
            state_next = S_IDLE;
         end
         S_T1: begin
            busrq_n    = 1'b0;
            bus_oe     = 1'b1;
            dma_ack    = 1'b1;
            state_next = S_T2;
         end
         S_T2: begin
            busrq_n = 1'b0;
            bus_oe  = 1'b1;
            mreq_n  = 1'b0;
            rd_n    = !rnw_reg;
            wr_n    = rnw_reg;
            if (wait_reg == WW'(WAIT_CYC))
               state_next = S_T3;
         end
         S_T3: begin
            busrq_n = 1'b0;
            bus_oe  = 1'b1;
            mreq_n  = 1'b0;
            rd_n    = !rnw_reg;
            wr_n    = rnw_reg;
            if (dma_req && burst_reg < BW'(MAX_BURST - 1))
               state_next = S_T1;
            else
               state_next = S_REL;
         end
         S_REL: begin
            if (busak_s_reg)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      dma_done  = done_reg || (state_reg == S_ABORT);
      dma_rdata = rdata_reg;
      d_oe      = (bus_oe && !rnw_reg) || dhold_reg;
      a_out     = bus_oe ? addr_reg : 16'h0000;
      d_out     = d_oe ? wdata_reg : 8'h00;
   end

endmodule

// File: doc/z80_dma_arbiter.md
Name: z80_dma_arbiter

Overview:
- Shares the Z80 system bus (16-bit address, 8-bit data, MREQ/RD/WR) between the CPU and one on-chip DMA requester, using the CPU's BUSRQ/BUSAK handshake.
- Acquires the bus, runs one or more T1/T2/T3 memory cycles on the requester's behalf with programmable wait states, then releases the bus.
- Enforces a burst limit and a CPU hold-off so the CPU always makes progress.
- Sits between the DMA engines and the CPU socket pins in the testbench and FPGA top.

Parameters:
- WAIT_CYC, 1: extra cycles added to T2 per memory cycle (0..15).
- MAX_BURST, 4: maximum memory cycles per bus tenure (>=1).
- HOLDOFF, 8: idle cycles required after release before BUSRQ may be reasserted (>=1).
- ACK_TIMEOUT, 64: cycles to wait for BUSAK before aborting.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- dma_req  in  1  request level; requester holds it and dma_rnw/addr/wdata stable until dma_ack.
- dma_rnw  in  1  1 = read, 0 = write.
- dma_addr  in  16  memory address.
- dma_wdata  in  8  write data.
- dma_ack  out  1  1-cycle pulse: request latched; next request may be presented.
- dma_done  out  1  1-cycle pulse: cycle finished (or aborted).
- dma_err  out  1  valid with dma_done; 1 = BUSAK timeout, no bus cycle run.
- dma_rdata  out  8  read data, valid from dma_done and held until the next dma_done.
- busrq_n  out  1  to CPU BUSRQ.
- busak_n  in  1  from CPU BUSAK; asynchronous.
- bus_oe  out  1  arbiter drives a_out, mreq_n, rd_n and wr_n onto the bus.
- a_out  out  16  address.
- d_out  out  8  write data.
- d_oe  out  1  data bus drive enable.
- d_in  in  8  data bus sampled value.
- mreq_n, rd_n, wr_n  out  1 each  bus strobes; meaningful only while bus_oe = 1.

Behaviour:
- Reset values (driven on the first clock with rst = 1, including mid-cycle):
  - Bus side: busrq_n = 1, bus_oe = 0, d_oe = 0, mreq_n = rd_n = wr_n = 1, a_out = 0, d_out = 0.
  - Requester side: dma_ack = dma_done = dma_err = 0, dma_rdata = 0.
  - Internal: state = IDLE, hold-off counter = 0 (no hold-off after reset), busak synchroniser = 1,1.
- busak_n passes through a 2-flop synchroniser (busak_s); only busak_s is used.
- IDLE: all bus outputs at reset values. Go to ACQ when dma_req = 1 and the hold-off counter = 0. The hold-off counter decrements each cycle while nonzero.
- ACQ:
  - busrq_n = 0; a timeout counter runs from 0.
  - busak_s = 0 -> T1.
  - Timeout counter reaches ACK_TIMEOUT-1 -> ABORT.
- ABORT (1 cycle): busrq_n = 1, dma_ack = 1, dma_done = 1, dma_err = 1, then IDLE with hold-off loaded. A late BUSAK is handled by REL-style waiting: IDLE does not request again until busak_s = 1.
- T1 (1 cycle):
  - Latch dma_rnw/addr/wdata; dma_ack = 1.
  - bus_oe = 1, a_out = latched addr, strobes high.
  - For a write: d_out = wdata, d_oe = 1.
- T2 (WAIT_CYC+1 cycles): mreq_n = 0; rd_n = 0 for a read, wr_n = 0 for a write; d_oe held for writes.
- T3 (1 cycle):
  - Strobes still asserted.
  - Read: d_in captured into dma_rdata at the end of T3.
  - Next cycle: strobes high, dma_done = 1.
  - Decision at the end of T3: if dma_req = 1 and burst count < MAX_BURST-1, go to T1 (bus_oe kept 1, burst count + 1); otherwise go to REL.
- REL:
  - bus_oe = 0, d_oe = 0, busrq_n = 1.
  - Wait for busak_s = 1, then IDLE with hold-off = HOLDOFF.
- d_oe is deasserted one cycle after wr_n rises (data hold).
- dma_done for the last cycle of a burst occurs in the first REL cycle.
- dma_req dropping during ACQ: the bus is still acquired, then released immediately (T1 is not entered, no dma_ack, no dma_done).
- Burst counter is 0 at T1 of the first cycle of each tenure.
- Per-access latency from ACQ entry with busak_s already low: T1 at +1, dma_done at +WAIT_CYC+4.

Test Plan:
- Single read, WAIT_CYC = 1, CPU model asserts BUSAK 3 cycles after BUSRQ, d_in = 0xA5 at 0x1234 -> exactly one mreq_n/rd_n low window of 3 cycles, a_out = 0x1234, dma_rdata = 0xA5 with dma_done, busrq_n high afterwards, no new BUSRQ for 8 cycles.
- Single write of 0x3C to 0x8000 -> wr_n low 3 cycles, d_oe high from T1 through one cycle after wr_n rises, d_out = 0x3C, rd_n stays 1.
- dma_req held for 6 back-to-back reads, MAX_BURST = 4 -> 4 cycles in the first tenure, BUSRQ released, hold-off of HOLDOFF cycles, then 2 cycles in a second tenure; 6 dma_ack and 6 dma_done pulses.
- BUSAK never asserted, ACK_TIMEOUT = 64 -> busrq_n low for exactly 64 cycles, then dma_done = dma_err = 1, no strobe activity, bus_oe stays 0.
- rst pulsed during T2 of a write -> next edge: bus_oe = 0, d_oe = 0, strobes high, busrq_n = 1, no dma_done; a fresh request afterwards completes normally.
- dma_req withdrawn while in ACQ -> BUSRQ released after BUSAK, with zero strobe activity and no dma_ack.
